jtopl_mmr_wr: RTL and testbench
===============================

Name: jtopl_mmr_wr

Overview:
- CPU-side write front end for the OPL core. Decodes two-port (address/data) CPU writes into the per-slot and per-channel update strobes consumed by the operator/channel register file.
- Drives the register file's sel_group/sel_sub/up_* strobes, the din bus and the write pulse.
- Holds each update until a full 18-slot pass has completed, so every slot sees it. Reports busy to the CPU.
- Sits between the CPU bus and the register file, in the same cen domain as the slot counter.

Parameters:
- OPL_TYPE, 1, 1 = OPL (waveform-select registers and wave_mode ignored), 2 = OPL2 (0xE0-0xF5 and reg 0x01 bit 5 enabled)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable shared with the slot counter
- cpu_cs_n  in  1  chip select, active low
- cpu_wr_n  in  1  write strobe, active low
- cpu_addr  in  1  0 = address port, 1 = data port
- cpu_din  in  8  CPU data
- zero  in  1  slot-counter wrap marker, valid on cen cycles
- write  out  1  register-file write pulse
- dout  out  8  data to register file (its din)
- sel_group  out  2  target group
- sel_sub  out  3  target subslot
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon  out  1 each  update strobes
- rhy_en  out  1  rhythm mode enable (reg 0xBD bit 5)
- rhy_kon  out  5  rhythm key-on (reg 0xBD bits 4:0)
- wave_mode  out  1  reg 0x01 bit 5; forced 0 when OPL_TYPE==1
- busy  out  1  an update is in flight
- overrun  out  1  sticky: a data write was dropped

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, the address latch is 0x00, the FSM is IDLE, and the pending buffer is empty.
- Reset mid-operation aborts the active update and clears pending. No strobe survives reset.
- CPU write detect:
  - we = !cpu_cs_n & !cpu_wr_n, registered on clk. It is not gated by cen.
  - One event is generated on the 0->1 edge of the registered we. The address and data are sampled on that edge.
- Address-port event: addr_latch <= cpu_din, in the same cycle. It never affects busy.
- Data-port event decode, using A = addr_latch:
  - Operator ranges 0x20/0x40/0x60/0x80/0xE0 + off, with off = A[4:0].
    - Valid when A[4:3] <= 2 and A[2:0] <= 5.
    - sel_group = A[4:3], sel_sub = A[2:0].
  - Channel ranges 0xA0-0xA8, 0xB0-0xB8, 0xC0-0xC8, channel n = A[3:0] <= 8.
    - sel_group = n/3, sel_sub = n%3.
  - 0xBD: rhy_en <= d[5], rhy_kon <= d[4:0], applied immediately. No busy, no FSM.
  - 0x01: wave_mode <= d[5] (OPL_TYPE != 1 only), applied immediately.
  - Unmapped address (including invalid offsets, and 0xE0 range when OPL_TYPE==1): ignored. No busy, no overrun.
- Update FSM (advances only on cen except the load):
  - IDLE: on a valid slot/channel data event, load it into active and go to ARM. Set busy=1, drive dout, sel_*, and exactly one up_* high.
  - ARM: write=1. At the first cen, write drops to 0 and the FSM goes to WAIT0.
  - WAIT0: on cen & zero, go to WAIT1.
  - WAIT1: on cen & zero, the update is complete. Drop up_* to 0.
    - If pending is valid, load it into active and go to ARM. busy stays 1.
    - Otherwise go to IDLE with busy=0.
  - dout/sel_*/up_* are stable from load to completion, which is at least 18 cen cycles after write falls.
- Pending buffer: one entry.
  - A valid data event while busy fills pending if empty.
  - If pending is full, the event is dropped and overrun <= 1. overrun clears only on reset.
  - A pending update with the same address as the active one is still executed in order.
- Simultaneous events:
  - Completion in WAIT1 and a new data event in the same clk: the new event goes to pending if pending is empty, else it is dropped. Then pending (which may be the new event) is loaded.
  - Address and data writes cannot coincide; they are single events per edge.

Decomposition:
- Shared package jtopl_pkg holds:
  - Register base constants: 0x20, 0x40, 0x60, 0x80, 0xE0, 0xA0, 0xB0, 0xC0, 0xBD, 0x01.
  - FSM state encoding: IDLE, ARM, WAIT0, WAIT1.
  - The update-kind enumeration, one per up_* strobe.
- One natural sub-module, jtopl_mmr_dec: a purely combinational map from address to {kind, group, sub, valid, global}. The FSM, pending buffer and edge detect stay in the top.

Test Plan:
- Address 0x43, data 0x15, no cen stalls -> up_ksl_tl=1, sel_group=0, sel_sub=3, dout=0x15, write high for 1 cen. busy falls on the second zero; up_ksl_tl falls at the same moment.
- Address 0xB5, data 0x2A -> up_fnumhi=1, sel_group=1, sel_sub=2, dout=0x2A.
- Address 0xBD, data 0x3F -> rhy_en=1, rhy_kon=0x1F next clk, busy stays 0. Address 0x26, data 0x11 -> ignored, no strobe.
- Three back-to-back data writes (0x20, 0x60, 0x80) inside one busy window -> 0x20 and 0x60 execute in order with no gap in busy. 0x80 is dropped and overrun=1.
- OPL_TYPE=1: address 0xE0 and address 0x01, data 0x20 -> no up_wav, wave_mode=0. OPL_TYPE=2: same writes -> up_wav asserted, wave_mode=1.
- Assert rst_n low while in WAIT0 with pending full -> all outputs 0 immediately. After release, a fresh write executes normally.

Source files
------------

// File: rtl/jtopl_pkg.sv
// ============================================================================
// Module      : jtopl_pkg
// Description : Shared constants, FSM states and update kinds for the OPL
//               CPU write front end.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package jtopl_pkg;

    localparam logic [7:0] BASE_MULT   = 8'h20;
    localparam logic [7:0] BASE_KSL_TL = 8'h40;
    localparam logic [7:0] BASE_AR_DR  = 8'h60;
    localparam logic [7:0] BASE_SL_RR  = 8'h80;
    localparam logic [7:0] BASE_WAV    = 8'hE0;
    localparam logic [7:0] BASE_FNUMLO = 8'hA0;
    localparam logic [7:0] BASE_FNUMHI = 8'hB0;
    localparam logic [7:0] BASE_FBCON  = 8'hC0;
    localparam logic [7:0] ADDR_RHY    = 8'hBD;
    localparam logic [7:0] ADDR_WAVE   = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_WAIT0 = 2'd2,
        ST_WAIT1 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        UP_MULT   = 3'd0,
        UP_KSL_TL = 3'd1,
        UP_AR_DR  = 3'd2,
        UP_SL_RR  = 3'd3,
        UP_WAV    = 3'd4,
        UP_FNUMLO = 3'd5,
        UP_FNUMHI = 3'd6,
        UP_FBCON  = 3'd7
    } kind_t;

    function automatic logic [7:0] kind_onehot(input kind_t k);
        return 8'b1 << k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtopl_mmr_dec.sv
// ============================================================================
// Module      : jtopl_mmr_dec
// Description : Combinational map from register address to update target.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jtopl_mmr_dec
    import jtopl_pkg::*;
#(
    parameter int OPL_TYPE = 1
) (
    input  logic [7:0] addr,
    output kind_t      kind,
    output logic [1:0] group,
    output logic [2:0] sub,
    output logic       valid,
    output logic       is_rhy,
    output logic       is_wav
);

    logic [7:0] w_op_base;
    logic [7:0] w_ch_base;
    logic       w_op_ok;
    logic       w_ch_ok;

    always_comb begin
        kind      = UP_MULT;
        group     = 2'd0;
        sub       = 3'd0;
        valid     = 1'b0;
        w_op_base = {addr[7:5], 5'd0};
        w_ch_base = {addr[7:4], 4'd0};
        w_op_ok   = (addr[4:3] <= 2'd2) && (addr[2:0] <= 3'd5);
        w_ch_ok   = (addr[3:0] <= 4'd8);
        is_rhy    = (addr == ADDR_RHY);
        is_wav    = (addr == ADDR_WAVE) && (OPL_TYPE != 1);

        case (w_op_base)
            BASE_MULT:   begin kind = UP_MULT;   valid = w_op_ok; end
            BASE_KSL_TL: begin kind = UP_KSL_TL; valid = w_op_ok; end
            BASE_AR_DR:  begin kind = UP_AR_DR;  valid = w_op_ok; end
            BASE_SL_RR:  begin kind = UP_SL_RR;  valid = w_op_ok; end
            BASE_WAV:    begin kind = UP_WAV;    valid = w_op_ok && (OPL_TYPE != 1); end
            default:     ;
        endcase
        if (valid) begin
            group = addr[4:3];
            sub   = addr[2:0];
        end

        // Channel n maps to group n/3, sub n%3; 3-bit wraparound handles n=8.
        if (w_ch_ok && (w_ch_base == BASE_FNUMLO || w_ch_base == BASE_FNUMHI ||
                        w_ch_base == BASE_FBCON)) begin
            valid = 1'b1;
            kind  = (w_ch_base == BASE_FNUMLO) ? UP_FNUMLO :
                    (w_ch_base == BASE_FNUMHI) ? UP_FNUMHI : UP_FBCON;
            group = (addr[3:0] >= 4'd6) ? 2'd2 : (addr[3:0] >= 4'd3) ? 2'd1 : 2'd0;
            sub   = (addr[3:0] >= 4'd6) ? addr[2:0] - 3'd6 :
                    (addr[3:0] >= 4'd3) ? addr[2:0] - 3'd3 : addr[2:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/jtopl_mmr_wr.sv
// ============================================================================
// Module      : jtopl_mmr_wr
// Description : CPU write front end: turns address/data port writes into
//               register-file update strobes held for a full slot pass.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jtopl_mmr_wr
    import jtopl_pkg::*;
#(
    parameter int OPL_TYPE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cpu_cs_n,
    input  logic       cpu_wr_n,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_din,
    input  logic       zero,
    output logic       write,
    output logic [7:0] dout,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       wave_mode,
    output logic       busy,
    output logic       overrun
);

    logic       r_we, r_we_d, r_port;
    logic [7:0] r_din, r_addr_latch;
    state_t     r_state;
    logic [7:0] r_up;

    logic       r_pend_valid;
    kind_t      r_pend_kind;
    logic [1:0] r_pend_grp;
    logic [2:0] r_pend_sub;
    logic [7:0] r_pend_din;

    kind_t      w_kind, w_ld_kind;
    logic [1:0] w_grp, w_ld_grp;
    logic [2:0] w_sub, w_ld_sub;
    logic [7:0] w_ld_din;
    logic       w_valid, w_rhy, w_wav;
    logic       w_event, w_data_ev, w_new, w_done, w_use_pend, w_load, w_fill, w_drop;

    jtopl_mmr_dec #(.OPL_TYPE(OPL_TYPE)) u_dec (
        .addr   (r_addr_latch),
        .kind   (w_kind),
        .group  (w_grp),
        .sub    (w_sub),
        .valid  (w_valid),
        .is_rhy (w_rhy),
        .is_wav (w_wav)
    );

    assign w_event    = r_we & ~r_we_d;
    assign w_data_ev  = w_event & r_port;
    assign w_new      = w_data_ev & w_valid;
    assign w_done     = (r_state == ST_WAIT1) & cen & zero;
    assign w_use_pend = w_done & r_pend_valid;
    assign w_load     = ((r_state == ST_IDLE) & w_new) | (w_done & (r_pend_valid | w_new));
    assign w_fill     = w_new & (r_state != ST_IDLE) & ~w_done & ~r_pend_valid;
    // A full pending slot loses the new event even when it is being drained.
    assign w_drop     = w_new & (r_state != ST_IDLE) & r_pend_valid;

    assign w_ld_kind  = w_use_pend ? r_pend_kind : w_kind;
    assign w_ld_grp   = w_use_pend ? r_pend_grp  : w_grp;
    assign w_ld_sub   = w_use_pend ? r_pend_sub  : w_sub;
    assign w_ld_din   = w_use_pend ? r_pend_din  : r_din;

    assign up_mult    = r_up[UP_MULT];
    assign up_ksl_tl  = r_up[UP_KSL_TL];
    assign up_ar_dr   = r_up[UP_AR_DR];
    assign up_sl_rr   = r_up[UP_SL_RR];
    assign up_wav     = r_up[UP_WAV];
    assign up_fnumlo  = r_up[UP_FNUMLO];
    assign up_fnumhi  = r_up[UP_FNUMHI];
    assign up_fbcon   = r_up[UP_FBCON];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_we_d       <= 1'b0;
            r_port       <= 1'b0;
            r_din        <= 8'd0;
            r_addr_latch <= 8'd0;
            r_state      <= ST_IDLE;
            r_up         <= 8'd0;
            r_pend_valid <= 1'b0;
            r_pend_kind  <= UP_MULT;
            r_pend_grp   <= 2'd0;
            r_pend_sub   <= 3'd0;
            r_pend_din   <= 8'd0;
            write        <= 1'b0;
            dout         <= 8'd0;
            sel_group    <= 2'd0;
            sel_sub      <= 3'd0;
            rhy_en       <= 1'b0;
            rhy_kon      <= 5'd0;
            wave_mode    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            r_we   <= ~cpu_cs_n & ~cpu_wr_n;
            r_we_d <= r_we;
            r_port <= cpu_addr;
            r_din  <= cpu_din;

            if (w_event && !r_port)
                r_addr_latch <= r_din;
            if (w_data_ev && w_rhy) begin
                rhy_en  <= r_din[5];
                rhy_kon <= r_din[4:0];
            end
            if (w_data_ev && w_wav)
                wave_mode <= r_din[5];
            if (w_drop)
                overrun <= 1'b1;

            if (w_fill) begin
                r_pend_valid <= 1'b1;
                r_pend_kind  <= w_kind;
                r_pend_grp   <= w_grp;
                r_pend_sub   <= w_sub;
                r_pend_din   <= r_din;
            end else if (w_use_pend) begin
                r_pend_valid <= 1'b0;
            end

            if (w_load) begin
                r_state   <= ST_ARM;
                write     <= 1'b1;
                busy      <= 1'b1;
                dout      <= w_ld_din;
                sel_group <= w_ld_grp;
                sel_sub   <= w_ld_sub;
                r_up      <= kind_onehot(w_ld_kind);
            end else begin
                case (r_state)
                    ST_ARM: if (cen) begin
                        write   <= 1'b0;
                        r_state <= ST_WAIT0;
                    end
                    ST_WAIT0: if (cen && zero) r_state <= ST_WAIT1;
                    ST_WAIT1: if (w_done) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        r_up    <= 8'd0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtopl_mmr_wr.sv
// ============================================================================
// Module      : tb_jtopl_mmr_wr
// Description : Self-checking bench for jtopl_mmr_wr (OPL2 and OPL instances).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_jtopl_mmr_wr;

    logic       clk = 1'b0;
    logic       rst_n, cen, zero, cpu_cs_n, cpu_wr_n, cpu_addr;
    logic [7:0] cpu_din;

    logic       write, rhy_en, wave_mode, busy, overrun;
    logic [7:0] dout;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic [4:0] rhy_kon;
    logic       u_mult, u_ksl, u_ardr, u_slrr, u_wav, u_flo, u_fhi, u_fb;

    logic       b_write, b_rhy_en, b_wave_mode, b_busy, b_overrun;
    logic [7:0] b_dout;
    logic [1:0] b_sel_group;
    logic [2:0] b_sel_sub;
    logic [4:0] b_rhy_kon;
    logic       b_mult, b_ksl, b_ardr, b_slrr, b_wav, b_flo, b_fhi, b_fb;

    logic [7:0]  up_bus, b_up_bus;
    logic [30:0] outs, b_outs;
    assign up_bus   = {u_fb, u_fhi, u_flo, u_wav, u_slrr, u_ardr, u_ksl, u_mult};
    assign b_up_bus = {b_fb, b_fhi, b_flo, b_wav, b_slrr, b_ardr, b_ksl, b_mult};
    assign outs   = {write, dout, sel_group, sel_sub, up_bus, rhy_en, rhy_kon,
                     wave_mode, busy, overrun};
    assign b_outs = {b_write, b_dout, b_sel_group, b_sel_sub, b_up_bus, b_rhy_en,
                     b_rhy_kon, b_wave_mode, b_busy, b_overrun};

    jtopl_mmr_wr #(.OPL_TYPE(2)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .zero(zero), .write(write), .dout(dout),
        .sel_group(sel_group), .sel_sub(sel_sub), .up_mult(u_mult), .up_ksl_tl(u_ksl),
        .up_ar_dr(u_ardr), .up_sl_rr(u_slrr), .up_wav(u_wav), .up_fnumlo(u_flo),
        .up_fnumhi(u_fhi), .up_fbcon(u_fb), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
        .wave_mode(wave_mode), .busy(busy), .overrun(overrun)
    );

    jtopl_mmr_wr #(.OPL_TYPE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .zero(zero), .write(b_write), .dout(b_dout),
        .sel_group(b_sel_group), .sel_sub(b_sel_sub), .up_mult(b_mult), .up_ksl_tl(b_ksl),
        .up_ar_dr(b_ardr), .up_sl_rr(b_slrr), .up_wav(b_wav), .up_fnumlo(b_flo),
        .up_fnumhi(b_fhi), .up_fbcon(b_fb), .rhy_en(b_rhy_en), .rhy_kon(b_rhy_kon),
        .wave_mode(b_wave_mode), .busy(b_busy), .overrun(b_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cen_mode = 0;   // 0: always on, 1: random stalls, 2: held off
    int slot = 0;

    // Slot counter: 18 positions, zero flags the wrap position.
    initial begin
        cen  = 1'b0;
        zero = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cen) slot = (slot == 17) ? 0 : slot + 1;
            case (cen_mode)
                0:       cen = 1'b1;
                1:       cen = ($urandom_range(0, 2) != 0);
                default: cen = 1'b0;
            endcase
            zero = (slot == 17);
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cpu_wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = a; cpu_din = d;
        @(negedge clk);
        cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
        @(negedge clk);
    endtask

    // Reference decode: up bit order {fbcon,fnumhi,fnumlo,wav,sl_rr,ar_dr,ksl_tl,mult}.
    function automatic void ref_decode(input logic [7:0] a, input int opl,
                                       output logic [7:0] up, output logic [1:0] g,
                                       output logic [2:0] s);
        int base, off, n;
        up = 8'h00; g = 2'd0; s = 3'd0;
        base = a / 32;
        off  = a % 32;
        if (off / 8 <= 2 && off % 8 <= 5) begin
            case (base)
                1: up = 8'h01;
                2: up = 8'h02;
                3: up = 8'h04;
                4: up = 8'h08;
                7: if (opl == 2) up = 8'h10;
                default: ;
            endcase
            if (up != 0) begin g = 2'(off / 8); s = 3'(off % 8); end
        end
        n = a % 16;
        if (n <= 8) begin
            case (a / 16)
                10: up = 8'h20;
                11: up = 8'h40;
                12: up = 8'h80;
                default: ;
            endcase
            if (a / 16 >= 10 && a / 16 <= 12) begin g = 2'(n / 3); s = 3'(n % 3); end
        end
    endfunction

    // Follows one update from write rising to completion on the second zero.
    task automatic track(input string nm, input logic [7:0] eup, input logic [1:0] eg,
                         input logic [2:0] es, input logic [7:0] ed, input logic more);
        int t, zs, cens;
        logic c, z, w;
        t = 0;
        while (write !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        check({nm, " write_rise"}, write, 1);
        check({nm, " busy"}, busy, 1);
        check({nm, " up"}, up_bus, eup);
        check({nm, " sel"}, {sel_group, sel_sub}, {eg, es});
        check({nm, " dout"}, dout, ed);
        zs = 0; cens = 0; t = 0;
        while (zs < 2 && t < 400) begin
            c = cen; z = zero; w = write;
            @(negedge clk);
            t++;
            if (!w && c) cens++;
            if (!w && c && z) zs++;
            if (w && c) check({nm, " write_fall"}, write, 0);
            if (zs < 2)
                check({nm, " hold"}, {busy, up_bus, sel_group, sel_sub, dout},
                      {1'b1, eup, eg, es, ed});
        end
        check({nm, " complete"}, zs, 2);
        check({nm, " span>=18"}, (cens >= 18), 1);
        check({nm, " busy_after"}, busy, more);
        if (!more) check({nm, " up_after"}, up_bus, 0);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] up;
        logic [1:0] grp;
        logic [2:0] sub;
    } vec_t;

    vec_t vt[12];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] eup, a, d;
        logic [1:0] eg;
        logic [2:0] es;
        logic       exp_rhy_en, exp_wave;
        logic [4:0] exp_rhy_kon;
        int         t;

        vt[0]  = '{8'h43, 8'h15, 8'h02, 2'd0, 3'd3};
        vt[1]  = '{8'hB5, 8'h2A, 8'h40, 2'd1, 3'd2};
        vt[2]  = '{8'h26, 8'h11, 8'h00, 2'd0, 3'd0};
        vt[3]  = '{8'h35, 8'h5A, 8'h01, 2'd2, 3'd5};
        vt[4]  = '{8'hC8, 8'h77, 8'h80, 2'd2, 3'd2};
        vt[5]  = '{8'hA9, 8'h01, 8'h00, 2'd0, 3'd0};
        vt[6]  = '{8'h9D, 8'h33, 8'h00, 2'd0, 3'd0};
        vt[7]  = '{8'hF5, 8'hC3, 8'h10, 2'd2, 3'd5};
        vt[8]  = '{8'h0A, 8'hFF, 8'h00, 2'd0, 3'd0};
        vt[9]  = '{8'h6E, 8'h44, 8'h00, 2'd0, 3'd0};
        vt[10] = '{8'h8C, 8'h9C, 8'h08, 2'd1, 3'd4};
        vt[11] = '{8'hA0, 8'h80, 8'h20, 2'd0, 3'd0};

        rst_n = 1'b0; cpu_cs_n = 1'b1; cpu_wr_n = 1'b1; cpu_addr = 1'b0; cpu_din = 8'h00;
        repeat (3) @(negedge clk);
        check("reset outs", outs, 0);
        check("reset outs opl1", b_outs, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post-reset outs", outs, 0);

        // Waveform select only exists on OPL2.
        cpu_wr(1'b0, 8'h01); cpu_wr(1'b1, 8'h20);
        check("wave_mode opl2", wave_mode, 1);
        check("wave_mode opl1", b_wave_mode, 0);
        cpu_wr(1'b0, 8'hE0); cpu_wr(1'b1, 8'h55);
        check("opl1 E0 ignored", {b_busy, b_up_bus}, 0);
        track("opl2 E0", 8'h10, 2'd0, 3'd0, 8'h55, 1'b0);
        exp_wave = 1'b1;

        cpu_wr(1'b0, 8'hBD); cpu_wr(1'b1, 8'h3F);
        check("rhythm", {rhy_en, rhy_kon}, {1'b1, 5'h1F});
        check("rhythm no busy", {busy, write, up_bus}, 0);
        exp_rhy_en = 1'b1; exp_rhy_kon = 5'h1F;

        cen_mode = 1;
        for (int i = 0; i < 12; i++) begin
            cpu_wr(1'b0, vt[i].addr);
            cpu_wr(1'b1, vt[i].din);
            if (vt[i].up != 8'h00)
                track($sformatf("vec%0d", i), vt[i].up, vt[i].grp, vt[i].sub, vt[i].din, 1'b0);
            else
                check($sformatf("vec%0d ignored", i), {busy, write, up_bus, overrun}, 0);
        end

        // Three data writes while the first is still armed: third is dropped.
        cen_mode = 2;
        repeat (3) @(negedge clk);
        cpu_wr(1'b0, 8'h20); cpu_wr(1'b1, 8'hA1);
        cpu_wr(1'b0, 8'h60); cpu_wr(1'b1, 8'hB2);
        cpu_wr(1'b0, 8'h80); cpu_wr(1'b1, 8'hC3);
        check("overrun set", overrun, 1);
        cen_mode = 0;
        track("b2b first", 8'h01, 2'd0, 3'd0, 8'hA1, 1'b1);
        track("b2b second", 8'h04, 2'd0, 3'd0, 8'hB2, 1'b0);
        check("overrun sticky", overrun, 1);

        cen_mode = 1;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 8'hBD;
                1:       a = 8'(($urandom_range(0, 1) != 0) ? 8'h01 : $urandom_range(8'hA0, 8'hC9));
                2:       a = 8'($urandom_range(8'hA0, 8'hC9));
                default: a = 8'($urandom_range(0, 255));
            endcase
            d = 8'($urandom_range(0, 255));
            ref_decode(a, 2, eup, eg, es);
            cpu_wr(1'b0, a);
            cpu_wr(1'b1, d);
            if (a == 8'hBD) begin exp_rhy_en = d[5]; exp_rhy_kon = d[4:0]; end
            if (a == 8'h01) exp_wave = d[5];
            if (eup != 8'h00)
                track($sformatf("rand%0d a=%0h", i, a), eup, eg, es, d, 1'b0);
            else
                check($sformatf("rand%0d idle a=%0h", i, a), {busy, write, up_bus}, 0);
            check($sformatf("rand%0d globals", i), {rhy_en, rhy_kon, wave_mode, b_wave_mode},
                  {exp_rhy_en, exp_rhy_kon, exp_wave, 1'b0});
        end

        // Reset while waiting for the slot pass, with the pending slot full.
        cen_mode = 2;
        repeat (3) @(negedge clk);
        cpu_wr(1'b0, 8'h40); cpu_wr(1'b1, 8'h11);
        cpu_wr(1'b0, 8'h41); cpu_wr(1'b1, 8'h22);
        check("pre-reset busy", busy, 1);
        cen_mode = 0;
        t = 0;
        while (write !== 1'b0 && t < 50) begin @(negedge clk); t++; end
        check("pre-reset write fell", write, 0);
        rst_n = 1'b0;
        #1;
        check("async reset outs", outs, 0);
        check("async reset outs opl1", b_outs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cpu_wr(1'b0, 8'h63); cpu_wr(1'b1, 8'h5C);
        track("after reset", 8'h04, 2'd0, 3'd3, 8'h5C, 1'b0);
        check("after reset overrun", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
